preadder_sched: RTL and testbench

// - Round-robin scheduler sharing one preadder (1-cycle registered Z0/Z1, modes on mode1/mode2) among N_REQ burst requesters.
// - Grants a requester, streams its beats (ack/sel drive the top-level X/Y operand mux) and drives mode1/mode2 per beat.
// - Emits output valids, tag and last flag aligned with the preadder's registered Z0/Z1.
// - Sits between the Fp2/Fp12 operation sequencers and preadder, ahead of the multiplier array.

---
 rtl/preadder_sched_if.sv | 39 +++
 rtl/preadder_sched.sv | 188 ++++++++++++++++++
 tb/tb_preadder_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/preadder_sched_if.sv
// preadder_sched_if: bundle between the operation sequencers (requesters)
// and the preadder scheduler.
//   Requester side : req, req_mode1, req_mode2, req_len, req_tag
//   Scheduler side : gnt, ack, sel, mode1, mode2, z0_valid, z1_valid,
//                    out_tag, out_last, busy
// Modports: master = requester/sequencer side, slave = scheduler.
interface preadder_sched_if #(
   parameter int N_REQ = 2,
   parameter int LEN_W = 4,
   parameter int TAG_W = 4
);
   localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]       req;
   logic [2*N_REQ-1:0]     req_mode1;
   logic [2*N_REQ-1:0]     req_mode2;
   logic [LEN_W*N_REQ-1:0] req_len;
   logic [TAG_W*N_REQ-1:0] req_tag;
   logic [N_REQ-1:0]       gnt;
   logic [N_REQ-1:0]       ack;
   logic [SEL_W-1:0]       sel;
   logic [1:0]             mode1;
   logic [1:0]             mode2;
   logic                   z0_valid;
   logic                   z1_valid;
   logic [TAG_W-1:0]       out_tag;
   logic                   out_last;
   logic                   busy;

   modport master (
      output req, req_mode1, req_mode2, req_len, req_tag,
      input  gnt, ack, sel, mode1, mode2, z0_valid, z1_valid, out_tag, out_last, busy
   );

   modport slave (
      input  req, req_mode1, req_mode2, req_len, req_tag,
      output gnt, ack, sel, mode1, mode2, z0_valid, z1_valid, out_tag, out_last, busy
   );
endinterface

// File: rtl/preadder_sched.sv
// preadder_sched: round-robin scheduler sharing one preadder among N_REQ
// burst requesters. A granted burst is streamed one beat per cycle (ack/sel
// steer the X/Y operand mux, mode1/mode2 drive the preadder) and the
// valids/tag/last flag are delayed one cycle to line up with Z0/Z1.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sched (slave)   request bundle in, grant/beat/output-alignment bundle out
//   perf_busy_cyc   RUN-cycle counter   (only with PREADDER_SCHED_PERF_EN)
//   perf_bursts     grant counter       (only with PREADDER_SCHED_PERF_EN)
// Build option: define PREADDER_SCHED_PERF_EN to add the two perf counters.
module preadder_sched #(
   parameter int N_REQ = 2,
   parameter int LEN_W = 4,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   preadder_sched_if.slave        sched
`ifdef PREADDER_SCHED_PERF_EN
   ,
   output logic [31:0]            perf_busy_cyc,
   output logic [31:0]            perf_bursts
`endif
);
   localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   rr_q, rr_d, own_q, own_d, win_s;
   logic [SEL_W:0]     idx_s;
   logic               found_s, last_s, grant_s, run_s;
   logic [LEN_W-1:0]   cnt_q, cnt_d, win_len_s;
   logic [1:0]         m1_q, m1_d, m2_q, m2_d, win_m1_s, win_m2_s;
   logic [TAG_W-1:0]   tag_q, tag_d, win_tag_s, otag_q;
   logic               first_q, first_d;
   logic               z0v_q, z1v_q, olast_q;

   assign run_s   = (state_q == ST_RUN);
   assign last_s  = run_s && (cnt_q == LEN_W'(1));
   // Arbitrate from IDLE or on the final beat so back-to-back bursts have no bubble.
   assign grant_s = !rst && found_s && (!run_s || last_s);

   // Round-robin search: first set req at or after the rr pointer.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      idx_s   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx_s   = {1'b0, rr_q} + (SEL_W+1)'(k);
         idx_s   = (idx_s >= (SEL_W+1)'(N_REQ)) ? idx_s - (SEL_W+1)'(N_REQ) : idx_s;
         win_s   = (sched.req[idx_s[SEL_W-1:0]] && !found_s) ? idx_s[SEL_W-1:0] : win_s;
         found_s = found_s | sched.req[idx_s[SEL_W-1:0]];
      end
   end

   // Select the winning requester's burst descriptor.
   always_comb begin
      win_m1_s  = 2'b00;
      win_m2_s  = 2'b00;
      win_len_s = '0;
      win_tag_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         win_m1_s  = win_m1_s  | ({2{win_s == SEL_W'(i)}}     & sched.req_mode1[2*i +: 2]);
         win_m2_s  = win_m2_s  | ({2{win_s == SEL_W'(i)}}     & sched.req_mode2[2*i +: 2]);
         win_len_s = win_len_s | ({LEN_W{win_s == SEL_W'(i)}} & sched.req_len[LEN_W*i +: LEN_W]);
         win_tag_s = win_tag_s | ({TAG_W{win_s == SEL_W'(i)}} & sched.req_tag[TAG_W*i +: TAG_W]);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = found_s ? ST_RUN : ST_IDLE;
         ST_RUN:  state_d = (last_s && !found_s) ? ST_IDLE : ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   // Burst bookkeeping next-state: latch descriptor on grant, count beats otherwise.
   always_comb begin
      rr_d    = rr_q;
      own_d   = own_q;
      cnt_d   = cnt_q;
      m1_d    = m1_q;
      m2_d    = m2_q;
      tag_d   = tag_q;
      first_d = first_q;
      if (grant_s) begin
         own_d   = win_s;
         rr_d    = (win_s == SEL_W'(N_REQ-1)) ? '0 : win_s + SEL_W'(1);
         cnt_d   = (win_len_s == '0) ? LEN_W'(1) : win_len_s;
         m1_d    = win_m1_s;
         m2_d    = win_m2_s;
         tag_d   = win_tag_s;
         first_d = 1'b1;
      end else if (run_s) begin
         cnt_d   = cnt_q - LEN_W'(1);
         first_d = 1'b0;
      end else begin
         first_d = first_q;
      end
   end

   // Burst bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q    <= '0;
         own_q   <= '0;
         cnt_q   <= '0;
         m1_q    <= 2'b00;
         m2_q    <= 2'b00;
         tag_q   <= '0;
         first_q <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         own_q   <= own_d;
         cnt_q   <= cnt_d;
         m1_q    <= m1_d;
         m2_q    <= m2_d;
         tag_q   <= tag_d;
         first_q <= first_d;
      end
   end

   // Output-alignment stage: one cycle behind the beat, like the preadder's Z0/Z1.
   // A pair mode's first beat would combine with the previous burst's operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         z0v_q   <= 1'b0;
         z1v_q   <= 1'b0;
         olast_q <= 1'b0;
         otag_q  <= '0;
      end else begin
         z0v_q   <= run_s && !((m1_q == 2'b01) && first_q);
         z1v_q   <= run_s && !((m2_q == 2'b10) && first_q);
         olast_q <= last_s;
         otag_q  <= run_s ? tag_q : otag_q;
      end
   end

   // FSM outputs: grant pulse, beat strobe and operand/mode steering.
   always_comb begin
      sched.gnt   = '0;
      sched.ack   = '0;
      sched.sel   = run_s ? own_q : '0;
      sched.mode1 = run_s ? m1_q : 2'b00;
      sched.mode2 = run_s ? m2_q : 2'b00;
      for (int i = 0; i < N_REQ; i++) begin
         sched.gnt[i] = grant_s && (win_s == SEL_W'(i));
         sched.ack[i] = run_s && !rst && (own_q == SEL_W'(i));
      end
   end

   assign sched.busy     = run_s;
   assign sched.z0_valid = z0v_q;
   assign sched.z1_valid = z1v_q;
   assign sched.out_tag  = otag_q;
   assign sched.out_last = olast_q;

`ifdef PREADDER_SCHED_PERF_EN
   logic [31:0] pbusy_q, pburst_q;

   // Performance counters; wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         pbusy_q  <= 32'd0;
         pburst_q <= 32'd0;
      end else begin
         pbusy_q  <= pbusy_q + {31'd0, run_s};
         pburst_q <= pburst_q + {31'd0, grant_s};
      end
   end

   assign perf_busy_cyc = pbusy_q;
   assign perf_bursts   = pburst_q;
`endif
endmodule

// File: tb/tb_preadder_sched.sv
// tb_preadder_sched: randomized requesters drive the scheduler; a transaction
// level reference (pending-request table, round-robin pointer, remaining beat
// count of the active burst, one-cycle delayed beat record) predicts every
// output each cycle.
module tb_preadder_sched;
   localparam int N  = 3;
   localparam int LW = 4;
   localparam int TW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   preadder_sched_if #(.N_REQ(N), .LEN_W(LW), .TAG_W(TW)) bus ();

`ifdef PREADDER_SCHED_PERF_EN
   logic [31:0] perf_busy_cyc, perf_bursts;
`endif

   preadder_sched #(.N_REQ(N), .LEN_W(LW), .TAG_W(TW)) dut (
      .clk   (clk),
      .rst   (rst),
      .sched (bus)
`ifdef PREADDER_SCHED_PERF_EN
      ,
      .perf_busy_cyc (perf_busy_cyc),
      .perf_bursts   (perf_bursts)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // requester-side state
   bit             pend [N];
   logic [1:0]     f_m1 [N];
   logic [1:0]     f_m2 [N];
   logic [LW-1:0]  f_len[N];
   logic [TW-1:0]  f_tag[N];

   // reference model state
   bit             m_run, m_first;
   int             m_own, m_rem, m_ptr;
   logic [1:0]     m_m1, m_m2;
   logic [TW-1:0]  m_tag;
   bit             p_v0, p_v1, p_last;
   logic [TW-1:0]  p_tag;
   int unsigned    e_busy, e_bursts;

   task automatic model_reset();
      m_run = 1'b0; m_first = 1'b0; m_own = 0; m_rem = 0; m_ptr = 0;
      p_v0 = 1'b0; p_v1 = 1'b0; p_last = 1'b0; p_tag = '0;
      e_busy = 0; e_bursts = 0;
   endtask

   initial begin
      bit            rst_now, granted;
      int            w;
      logic [N-1:0]  rv, e_gnt, e_ack;

      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; f_m1[i] = 2'b00; f_m2[i] = 2'b00; f_len[i] = '0; f_tag[i] = '0;
      end
      model_reset();

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         rst_now = (cyc < 2) || ($urandom % 200 == 0);

         // requesters: new bursts, occasional withdrawals; idle fields churn
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               f_m1[i]  = 2'($urandom_range(0, 3));
               f_m2[i]  = 2'($urandom_range(0, 3));
               f_len[i] = ($urandom % 4 == 0) ? LW'($urandom_range(0, 2)) : LW'($urandom_range(0, 15));
               f_tag[i] = TW'($urandom);
               pend[i]  = ($urandom % 3 == 0);
            end else if ($urandom % 50 == 0) begin
               pend[i] = 1'b0;
            end
         end
         for (int i = 0; i < N; i++) begin
            rv[i] = pend[i];
            bus.req_mode1[2*i +: 2]   = f_m1[i];
            bus.req_mode2[2*i +: 2]   = f_m2[i];
            bus.req_len[LW*i +: LW]   = f_len[i];
            bus.req_tag[TW*i +: TW]   = f_tag[i];
         end
         bus.req = rv;
         rst     = rst_now;
         #1;

         // round-robin decision of the reference
         granted = 1'b0;
         w = 0;
         if (!rst_now && (!m_run || m_rem == 1)) begin
            for (int k = 0; k < N; k++) begin
               if (!granted && rv[(m_ptr + k) % N]) begin
                  granted = 1'b1;
                  w = (m_ptr + k) % N;
               end
            end
         end

         if (!rst_now) begin
            e_gnt = '0; e_ack = '0;
            if (granted) e_gnt[w] = 1'b1;
            if (m_run) e_ack[m_own] = 1'b1;
            check_eq("gnt",      bus.gnt,            e_gnt);
            check_eq("ack",      bus.ack,            e_ack);
            check_eq("busy",     bus.busy,           m_run);
            check_eq("mode1",    bus.mode1,          m_run ? m_m1 : 2'b00);
            check_eq("mode2",    bus.mode2,          m_run ? m_m2 : 2'b00);
            if (m_run) check_eq("sel", bus.sel, m_own);
            check_eq("z0_valid", bus.z0_valid,       p_v0);
            check_eq("z1_valid", bus.z1_valid,       p_v1);
            check_eq("out_last", bus.out_last,       p_last);
            check_eq("out_tag",  bus.out_tag,        p_tag);
`ifdef PREADDER_SCHED_PERF_EN
            check_eq("perf_busy_cyc", perf_busy_cyc, e_busy);
            check_eq("perf_bursts",   perf_bursts,   e_bursts);
`endif
         end

         // advance the reference to the next clock edge
         if (rst_now) begin
            model_reset();
         end else begin
            p_v0   = m_run && !(m_m1 == 2'b01 && m_first);
            p_v1   = m_run && !(m_m2 == 2'b10 && m_first);
            p_last = m_run && (m_rem == 1);
            if (m_run) p_tag = m_tag;
            if (m_run) e_busy++;
            if (m_run) begin
               m_rem--;
               m_first = 1'b0;
               if (m_rem == 0) m_run = 1'b0;
            end
            if (granted) begin
               e_bursts++;
               m_run   = 1'b1;
               m_own   = w;
               m_m1    = f_m1[w];
               m_m2    = f_m2[w];
               m_tag   = f_tag[w];
               m_rem   = (f_len[w] == 0) ? 1 : int'(f_len[w]);
               m_first = 1'b1;
               m_ptr   = (w + 1) % N;
               pend[w] = 1'b0;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
